// File: rtl/strv32i_pkg.sv
// strv32i_pkg: shared definitions for the STRV32I fetch stage.
//   FETCH_DEPTH      default instruction FIFO depth
//   FETCH_MAX_OUTST  default limit on granted-but-unanswered imem requests
//   RV32I_NOP        canonical RV32I no-op (addi x0, x0, 0)
//   fetch_entry_t    one decoded-stage entry: {pc, instr}
package strv32i_pkg;

    localparam int FETCH_DEPTH     = 2;
    localparam int FETCH_MAX_OUTST = 2;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with registered storage.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       drop all contents at the next edge (wins over push/pop)
//   push/wdata  write an entry (accepted when not full, or when popping too)
//   pop         remove the head (ignored when empty)
//   rdata       head entry, combinational from storage
//   full/empty/count  occupancy status
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    // A one-entry FIFO still needs a one-bit pointer to index storage.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Explicit wrap keeps non-power-of-two depths correct.
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch stage between the PC unit and decode.
//   clk_in, rst_in                         clock, asynchronous active-low reset
//   flush_in                               redirect: drop buffered and in-flight fetches
//   fetch_addr_in/_valid_in/_ready_out     address stream from the PC unit
//   imem_req_out/_addr_out/_gnt_in         imem request channel
//   imem_rvalid_in/_rdata_in               imem in-order response channel
//   instr_valid_out/_ready_in              decode handshake
//   instr_out, instr_pc_out                head {instr, pc}
//
// Handshakes: a transfer happens in a cycle where both sides of the pair are
// high (fetch_addr_valid_in & fetch_addr_ready_out, imem_req_out & imem_gnt_in,
// instr_valid_out & instr_ready_in); valid never depends on the paired ready.
module instr_fetch_buffer
    import strv32i_pkg::*;
#(
    parameter int DEPTH     = FETCH_DEPTH,
    parameter int MAX_OUTST = FETCH_MAX_OUTST
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic [31:0] fetch_addr_in,
    input  logic        fetch_addr_valid_in,
    output logic        fetch_addr_ready_out,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int SW = CW + OW;

    logic [OW-1:0] outst;
    logic [OW-1:0] drop_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [OW-1:0] pend_cnt;
    logic          credit_ok;
    logic          handshake;
    logic          rsp_ok;
    logic          rsp_keep;
    logic          head_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pend_empty;
    logic          pend_full;
    logic [31:0]   rsp_pc;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Every in-flight request already owns a FIFO slot, so a response can
    // always be written without checking fullness.
    assign credit_ok = (({{OW{1'b0}}, fifo_cnt} + {{CW{1'b0}}, outst}) < SW'(DEPTH))
                     && (outst < OW'(MAX_OUTST));

    // Combinational outputs are forced low while reset is held so the stage
    // is silent immediately, not only after the next edge.
    assign imem_req_out         = rst_in & fetch_addr_valid_in & credit_ok & ~flush_in;
    assign imem_addr_out        = rst_in ? {fetch_addr_in[31:2], 2'b00} : 32'h0;
    assign handshake            = imem_req_out & imem_gnt_in;
    assign fetch_addr_ready_out = handshake;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok   = imem_rvalid_in & (outst != '0);
    assign rsp_keep = rsp_ok & (drop_cnt == '0) & ~flush_in;

    assign push_entry = '{pc: rsp_pc, instr: imem_rdata_in};

    assign instr_valid_out = ~fifo_empty;
    assign head_pop        = instr_valid_out & instr_ready_in & ~flush_in;
    assign instr_out       = instr_valid_out ? head_entry.instr : 32'h0;
    assign instr_pc_out    = instr_valid_out ? head_entry.pc    : 32'h0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            outst    <= '0;
            drop_cnt <= '0;
        end else begin
            case ({handshake, rsp_ok})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: outst <= outst;
            endcase
            // Everything still in flight at a redirect belongs to the old
            // path; the response landing in the flush cycle is dropped here.
            if (flush_in) begin
                drop_cnt <= outst - (rsp_ok ? OW'(1) : OW'(0));
            end else if (rsp_ok && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    // Pending-PC queue survives a flush: dropped responses still pop it so
    // later tags stay aligned with their responses.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTST)
    ) u_pend_q (
        .clk   (clk_in),
        .rst_n (rst_in),
        .clear (1'b0),
        .push  (handshake),
        .pop   (rsp_ok),
        .wdata (fetch_addr_in),
        .rdata (rsp_pc),
        .full  (pend_full),
        .empty (pend_empty),
        .count (pend_cnt)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (clk_in),
        .rst_n (rst_in),
        .clear (flush_in),
        .push  (rsp_keep),
        .pop   (head_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    a_rvalid_needs_outst: assert property (@(posedge clk_in) disable iff (!rst_in)
        imem_rvalid_in |-> (outst != '0));
    a_outst_tracks_queue: assert property (@(posedge clk_in) disable iff (!rst_in)
        outst == pend_cnt);
    a_pend_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
        handshake |-> !pend_full);
    a_pend_tag_present: assert property (@(posedge clk_in) disable iff (!rst_in)
        rsp_ok |-> !pend_empty);
    a_fifo_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
        rsp_keep |-> !fifo_full);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;
    import strv32i_pkg::*;

    localparam int DEPTH     = FETCH_DEPTH;
    localparam int MAX_OUTST = FETCH_MAX_OUTST;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        flush_in = 1'b0;
    logic [31:0] fetch_addr_in = 32'h0;
    logic        fetch_addr_valid_in = 1'b0;
    logic        fetch_addr_ready_out;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in = 1'b0;
    logic        imem_rvalid_in = 1'b0;
    logic [31:0] imem_rdata_in = 32'h0;
    logic        instr_valid_out;
    logic        instr_ready_in = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;

    always #5 clk_in = ~clk_in;

    instr_fetch_buffer dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .flush_in             (flush_in),
        .fetch_addr_in        (fetch_addr_in),
        .fetch_addr_valid_in  (fetch_addr_valid_in),
        .fetch_addr_ready_out (fetch_addr_ready_out),
        .imem_req_out         (imem_req_out),
        .imem_addr_out        (imem_addr_out),
        .imem_gnt_in          (imem_gnt_in),
        .imem_rvalid_in       (imem_rvalid_in),
        .imem_rdata_in        (imem_rdata_in),
        .instr_valid_out      (instr_valid_out),
        .instr_ready_in       (instr_ready_in),
        .instr_out            (instr_out),
        .instr_pc_out         (instr_pc_out)
    );

    // ---------------- reference model state ----------------
    // In-flight imem requests (oldest first); live=0 once a redirect orphaned it.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          live;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];   // expected decode stream {pc, instr}, head first
    logic [31:0] pc_cur;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    int p_valid, p_gnt, p_rvalid, p_ready, p_flush_pm;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},   {63'h0, imem_req_out},         64'h0);
        check({tag, "_ready"}, {63'h0, fetch_addr_ready_out}, 64'h0);
        check({tag, "_addr"},  {32'h0, imem_addr_out},        64'h0);
        check({tag, "_valid"}, {63'h0, instr_valid_out},      64'h0);
        check({tag, "_instr"}, {32'h0, instr_out},            64'h0);
        check({tag, "_pc"},    {32'h0, instr_pc_out},         64'h0);
    endtask

    // ---------------- driver: PC unit + imem model ----------------
    task automatic cycle();
        bit    resp;
        bit    credit;
        bit    exp_req;
        bit    hs;
        pend_t r;
        @(negedge clk_in);
        fetch_addr_valid_in = ($urandom_range(99) < p_valid);
        fetch_addr_in       = pc_cur;
        imem_gnt_in         = ($urandom_range(99) < p_gnt);
        flush_in            = ($urandom_range(999) < p_flush_pm);
        instr_ready_in      = ($urandom_range(99) < p_ready);
        resp                = (pend_q.size() != 0) && ($urandom_range(99) < p_rvalid);
        imem_rvalid_in      = resp;
        imem_rdata_in       = resp ? pend_q[0].data : $urandom();
        #2;
        // Fetch slots: every request in flight plus every buffered entry
        // occupies one of DEPTH slots.
        credit  = (pend_q.size() + exp_q.size() < DEPTH) && (pend_q.size() < MAX_OUTST);
        exp_req = fetch_addr_valid_in && credit && !flush_in;
        hs      = exp_req && imem_gnt_in;
        check("imem_req",   {63'h0, imem_req_out},         {63'h0, exp_req});
        check("addr_ready", {63'h0, fetch_addr_ready_out}, {63'h0, hs});
        check("imem_addr",  {32'h0, imem_addr_out},        {32'h0, pc_cur[31:2], 2'b00});
        @(posedge clk_in);
        #1;
        if (resp) begin
            r = pend_q.pop_front();
            if (r.live && !flush_in) exp_q.push_back({r.pc, r.data});
        end
        if (flush_in) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].live = 1'b0;
        end
        if (hs) begin
            pend_q.push_back('{pc: pc_cur, data: $urandom(), live: 1'b1});
            pc_cur = ($urandom_range(9) == 0) ? $urandom() : pc_cur + 32'd4;
        end
        if (flush_in) pc_cur = $urandom() & 32'hFFFF_FFFC;
    endtask

    task automatic run_phase(input int n, input int pv, input int pg, input int pr,
                             input int prdy, input int pf);
        p_valid = pv; p_gnt = pg; p_rvalid = pr; p_ready = prdy; p_flush_pm = pf;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic mid_reset();
        // Try to catch the stage busy on both sides; bounded either way.
        p_ready = 0;
        for (int i = 0; i < 200; i++) begin
            if (pend_q.size() >= 1 && exp_q.size() >= 1) break;
            cycle();
        end
        @(negedge clk_in);
        flush_in = 1'b0; imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0;
        instr_ready_in = 1'b0; fetch_addr_valid_in = 1'b1;
        #1;
        mon_en = 1'b0;
        rst_in = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        pend_q.delete();
        exp_q.delete();
        pc_cur = 32'h0000_0100;
        fetch_addr_in = pc_cur;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        mon_en = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk_in);
            #4;
            if (mon_en) begin
                check("instr_valid", {63'h0, instr_valid_out}, {63'h0, exp_q.size() != 0});
                if (instr_valid_out && exp_q.size() != 0) begin
                    check("instr_pc", {32'h0, instr_pc_out}, {32'h0, exp_q[0][63:32]});
                    check("instr",    {32'h0, instr_out},    {32'h0, exp_q[0][31:0]});
                    if (instr_ready_in && !flush_in) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        fetch_addr_valid_in = 1'b1;
        fetch_addr_in       = 32'h1234_5678;
        #2;
        check_outputs_zero("reset");
        pc_cur = 32'h0000_0006;
        fetch_addr_in = pc_cur;
        @(negedge clk_in);
        rst_in = 1'b1;
        mon_en = 1'b1;

        run_phase(40,  100, 100, 100, 100, 0);   // streaming, 1-cycle imem
        run_phase(30,  100, 100, 100,   0, 0);   // decode stalled
        run_phase(30,  100, 100, 100, 100, 0);   // drain
        run_phase(300, 100, 100,  60,  60, 60);  // redirects with traffic in flight
        run_phase(400,  70,  60,  50,  50, 20);  // mixed random
        mid_reset();
        run_phase(200,  80,  70,  60,  70, 30);
        mid_reset();
        run_phase(400,  90,  80,  70,  40, 40);

        @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
